// File: rtl/systolic_tile_ctrl.sv
// rtl/systolic_tile_ctrl.sv - pass sequencer driving the systolic array control inputs
//
// Purpose:
//   For every (weight tile, ifm tile) pair, runs one pass on the array:
//   CLEAR (reset_pe) -> FETCH (BUFFER_SIZE words from both RAMs) ->
//   FLUSH (drain the systolic skew) -> WRITE (SYSTOLIC_SIZE ofm rows) -> NEXT.
//   Weight tile is the outer loop, ifm tile the inner loop. The ofm rows of
//   all passes are written contiguously starting at ofm_base.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   start                        launch a job; sampled only while idle
//   num_ifm_tiles/num_wgt_tiles  tile counts, latched at start
//   ifm_base/wgt_base/ofm_base   base addresses, latched at start
//   busy, done                   job in progress / one-cycle completion pulse
//   ifm_we_a, wgt_we_a           read-only RAM ports, tied low
//   ifm_addr_a, wgt_addr_a       read addresses
//   read_en                      shift-RF advance
//   reset_pe                     PE accumulator clear
//   write_out_en                 PE array output shift
//   ofm_we_b, ofm_addr_b         ofm write enable / address
//   perf_cycles                  busy-cycle counter (only with PERF_CNT_EN)
//
// Build option:
//   PERF_CNT_EN  adds perf_cycles[31:0], a saturating count of busy cycles,
//                cleared on an accepted start and held while idle.

module systolic_tile_ctrl #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int BUFFER_SIZE   = 27,
  parameter int IFM_ADDR_W    = 19,
  parameter int WGT_ADDR_W    = 9,
  parameter int OFM_ADDR_W    = 22,
  parameter int TILE_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TILE_W-1:0]     num_ifm_tiles,
  input  logic [TILE_W-1:0]     num_wgt_tiles,
  input  logic [IFM_ADDR_W-1:0] ifm_base,
  input  logic [WGT_ADDR_W-1:0] wgt_base,
  input  logic [OFM_ADDR_W-1:0] ofm_base,
  output logic                  busy,
  output logic                  done,
`ifdef PERF_CNT_EN
  output logic [31:0]           perf_cycles,
`endif
  output logic                  ifm_we_a,
  output logic                  wgt_we_a,
  output logic [IFM_ADDR_W-1:0] ifm_addr_a,
  output logic [WGT_ADDR_W-1:0] wgt_addr_a,
  output logic                  read_en,
  output logic                  reset_pe,
  output logic                  write_out_en,
  output logic                  ofm_we_b,
  output logic [OFM_ADDR_W-1:0] ofm_addr_b
);

  // Last value of the in-state cycle counter for each multi-cycle state.
  localparam int FETCH_LAST = BUFFER_SIZE;
  localparam int FLUSH_LAST = 2 * SYSTOLIC_SIZE - 2;
  localparam int WRITE_LAST = SYSTOLIC_SIZE;
  localparam int CNT_MAX    = (FETCH_LAST > FLUSH_LAST)
                              ? ((FETCH_LAST > WRITE_LAST) ? FETCH_LAST : WRITE_LAST)
                              : ((FLUSH_LAST > WRITE_LAST) ? FLUSH_LAST : WRITE_LAST);
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_FLUSH,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TILE_W-1:0]     it_q, it_d;
  logic [TILE_W-1:0]     wt_q, wt_d;
  logic [TILE_W-1:0]     num_ifm_q, num_ifm_d;
  logic [TILE_W-1:0]     num_wgt_q, num_wgt_d;
  logic [IFM_ADDR_W-1:0] ifm_base_q, ifm_base_d;
  // First address of the current ifm / weight tile.
  logic [IFM_ADDR_W-1:0] ifm_tile_q, ifm_tile_d;
  logic [WGT_ADDR_W-1:0] wgt_tile_q, wgt_tile_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  read_en_q, read_en_d;
  logic                  reset_pe_q, reset_pe_d;
  logic                  write_out_en_q, write_out_en_d;
  logic                  ofm_we_q, ofm_we_d;
  logic [IFM_ADDR_W-1:0] ifm_addr_q, ifm_addr_d;
  logic [WGT_ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
  logic [OFM_ADDR_W-1:0] ofm_addr_q, ofm_addr_d;

  logic [TILE_W-1:0]     it_inc;
  logic [TILE_W-1:0]     wt_inc;

  assign it_inc = it_q + TILE_W'(1);
  assign wt_inc = wt_q + TILE_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    it_d       = it_q;
    wt_d       = wt_q;
    num_ifm_d  = num_ifm_q;
    num_wgt_d  = num_wgt_q;
    ifm_base_d = ifm_base_q;
    ifm_tile_d = ifm_tile_q;
    wgt_tile_d = wgt_tile_q;
    // The write pointer advances after every written row and is only
    // re-seeded by an accepted start, so passes land back to back.
    ofm_addr_d = ofm_we_q ? (ofm_addr_q + OFM_ADDR_W'(1)) : ofm_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_ifm_d  = num_ifm_tiles;
          num_wgt_d  = num_wgt_tiles;
          ifm_base_d = ifm_base;
          ifm_tile_d = ifm_base;
          wgt_tile_d = wgt_base;
          ofm_addr_d = ofm_base;
          it_d       = '0;
          wt_d       = '0;
          cnt_d      = '0;
          if ((num_ifm_tiles == '0) || (num_wgt_tiles == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (cnt_q == CNT_W'(FETCH_LAST)) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_LAST)) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (cnt_q == CNT_W'(WRITE_LAST)) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (it_inc == num_ifm_q) begin
          // Inner loop wrapped: rewind the ifm tile, step the weight tile.
          it_d       = '0;
          wt_d       = wt_inc;
          ifm_tile_d = ifm_base_q;
          wgt_tile_d = wgt_tile_q + WGT_ADDR_W'(BUFFER_SIZE);
          state_d    = (wt_inc == num_wgt_q) ? S_DONE : S_CLEAR;
        end else begin
          it_d       = it_inc;
          ifm_tile_d = ifm_tile_q + IFM_ADDR_W'(BUFFER_SIZE);
          state_d    = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so that they change
    // on the same edge as the state register.
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
    reset_pe_d     = (state_d == S_CLEAR);
    // FETCH cycle 0 only issues the first address; data shifts in from cycle 1.
    read_en_d      = ((state_d == S_FETCH) && (cnt_d != '0)) || (state_d == S_FLUSH);
    write_out_en_d = (state_d == S_WRITE) && (cnt_d < CNT_W'(SYSTOLIC_SIZE));
    // The ofm write trails the output shift by one cycle.
    ofm_we_d       = (state_d == S_WRITE) && (cnt_d != '0);

    ifm_addr_d = ifm_addr_q;
    wgt_addr_d = wgt_addr_q;
    if ((state_d == S_FETCH) && (cnt_d < CNT_W'(BUFFER_SIZE))) begin
      ifm_addr_d = ifm_tile_q + IFM_ADDR_W'(cnt_d);
      wgt_addr_d = wgt_tile_q + WGT_ADDR_W'(cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      it_q           <= '0;
      wt_q           <= '0;
      num_ifm_q      <= '0;
      num_wgt_q      <= '0;
      ifm_base_q     <= '0;
      ifm_tile_q     <= '0;
      wgt_tile_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      read_en_q      <= 1'b0;
      reset_pe_q     <= 1'b0;
      write_out_en_q <= 1'b0;
      ofm_we_q       <= 1'b0;
      ifm_addr_q     <= '0;
      wgt_addr_q     <= '0;
      ofm_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      it_q           <= it_d;
      wt_q           <= wt_d;
      num_ifm_q      <= num_ifm_d;
      num_wgt_q      <= num_wgt_d;
      ifm_base_q     <= ifm_base_d;
      ifm_tile_q     <= ifm_tile_d;
      wgt_tile_q     <= wgt_tile_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      read_en_q      <= read_en_d;
      reset_pe_q     <= reset_pe_d;
      write_out_en_q <= write_out_en_d;
      ofm_we_q       <= ofm_we_d;
      ifm_addr_q     <= ifm_addr_d;
      wgt_addr_q     <= wgt_addr_d;
      ofm_addr_q     <= ofm_addr_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // busy_q marks the cycle being counted, so the DONE cycle is included.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign ifm_we_a     = 1'b0;
  assign wgt_we_a     = 1'b0;
  assign ifm_addr_a   = ifm_addr_q;
  assign wgt_addr_a   = wgt_addr_q;
  assign read_en      = read_en_q;
  assign reset_pe     = reset_pe_q;
  assign write_out_en = write_out_en_q;
  assign ofm_we_b     = ofm_we_q;
  assign ofm_addr_b   = ofm_addr_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// tb/tb_systolic_tile_ctrl.sv - self-checking bench for systolic_tile_ctrl
module tb_systolic_tile_ctrl;
  localparam int S    = 16;
  localparam int B    = 27;
  localparam int IW   = 19;
  localparam int WW   = 9;
  localparam int OW   = 22;
  localparam int TW   = 16;
  localparam int PASS = 1 + (B + 1) + (2 * S - 1) + (S + 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [TW-1:0] num_ifm_tiles;
  logic [TW-1:0] num_wgt_tiles;
  logic [IW-1:0] ifm_base;
  logic [WW-1:0] wgt_base;
  logic [OW-1:0] ofm_base;
  logic          busy, done, ifm_we_a, wgt_we_a, read_en, reset_pe, write_out_en, ofm_we_b;
  logic [IW-1:0] ifm_addr_a;
  logic [WW-1:0] wgt_addr_a;
  logic [OW-1:0] ofm_addr_b;
`ifdef PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int     ni;
    int     nw;
    longint ib;
    longint wb;
    longint ob;
    int     repulse_k;
  } job_t;

  systolic_tile_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_ifm_tiles (num_ifm_tiles),
    .num_wgt_tiles (num_wgt_tiles),
    .ifm_base      (ifm_base),
    .wgt_base      (wgt_base),
    .ofm_base      (ofm_base),
    .busy          (busy),
    .done          (done),
`ifdef PERF_CNT_EN
    .perf_cycles   (perf_cycles),
`endif
    .ifm_we_a      (ifm_we_a),
    .wgt_we_a      (wgt_we_a),
    .ifm_addr_a    (ifm_addr_a),
    .wgt_addr_a    (wgt_addr_a),
    .read_en       (read_en),
    .reset_pe      (reset_pe),
    .write_out_en  (write_out_en),
    .ofm_we_b      (ofm_we_b),
    .ofm_addr_b    (ofm_addr_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // {busy, done, reset_pe, read_en, write_out_en, ofm_we_b, ifm_we_a, wgt_we_a}
  function automatic logic [7:0] obs_ctrl();
    return {busy, done, reset_pe, read_en, write_out_en, ofm_we_b, ifm_we_a, wgt_we_a};
  endfunction

  function automatic job_t make_job(int ni, int nw, longint ib, longint wb, longint ob, int rk);
    job_t j;
    j.ni = ni; j.nw = nw; j.ib = ib; j.wb = wb; j.ob = ob; j.repulse_k = rk;
    return j;
  endfunction

  // Expected outputs in busy cycle k (k=1 is the cycle after the start edge).
  // A job is ni*nw passes laid end to end, each PASS cycles long, then one DONE cycle.
  function automatic void model_cycle(input job_t j, input int k, output logic [7:0] ctrl,
                                      output bit addr_v, output longint ifm_e, output longint wgt_e,
                                      output bit ofm_v, output longint ofm_e);
    int p, off, c, np;
    np = j.ni * j.nw;
    ctrl = 8'h00; addr_v = 0; ofm_v = 0; ifm_e = 0; wgt_e = 0; ofm_e = 0;
    if (k == np * PASS + 1) begin
      ctrl = 8'b1100_0000;
    end else if (k <= np * PASS) begin
      p = (k - 1) / PASS;
      off = (k - 1) % PASS;
      ctrl[7] = 1'b1;
      if (off == 0) begin
        ctrl[5] = 1'b1;
      end else if (off <= B + 1) begin
        c = off - 1;
        ctrl[4] = (c >= 1);
        if (c < B) begin
          addr_v = 1;
          ifm_e = (j.ib + longint'(p % j.ni) * B + c) & ((64'd1 << IW) - 1);
          wgt_e = (j.wb + longint'(p / j.ni) * B + c) & ((64'd1 << WW) - 1);
        end
      end else if (off <= B + 2 * S) begin
        ctrl[4] = 1'b1;
      end else if (off <= B + 3 * S + 1) begin
        c = off - (B + 2 * S + 1);
        ctrl[3] = (c < S);
        ctrl[2] = (c >= 1);
        if (c >= 1) begin
          ofm_v = 1;
          ofm_e = (j.ob + longint'(p) * S + c - 1) & ((64'd1 << OW) - 1);
        end
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    num_ifm_tiles = '0; num_wgt_tiles = '0; ifm_base = '0; wgt_base = '0; ofm_base = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({obs_ctrl(), ifm_addr_a, wgt_addr_a, ofm_addr_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got ctrl=%b ifm=%0d wgt=%0d ofm=%0d want all 0",
               obs_ctrl(), ifm_addr_a, wgt_addr_a, ofm_addr_b);
    end
`ifdef PERF_CNT_EN
    vectors++;
    if (perf_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_perf got %0d want 0", perf_cycles);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs_ctrl() !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b want 00000000", obs_ctrl());
    end
  endtask

  // Jobs run back to back: each start is raised in the first idle cycle after
  // the previous DONE. One row re-pulses start mid-FLUSH with other settings.
  task automatic test_job_table();
    job_t jobs[$];
    job_t j;
    logic [7:0] ce;
    bit av, ov;
    longint ie, we, oe;
    int total, done_seen;
    jobs.push_back(make_job(1, 1, 0, 0, 0, 0));
    jobs.push_back(make_job(3, 2, 100, 10, 500, 0));
    jobs.push_back(make_job(0, 2, 5, 5, 5, 0));
    jobs.push_back(make_job(4, 0, 6, 6, 6, 0));
    jobs.push_back(make_job(1, 1, 200, 20, 1000, 1 + 1 + (B + 1) + 10));
    jobs.push_back(make_job(2, 2, (1 << IW) - 30, (1 << WW) - 40, (1 << OW) - 20, 0));
    for (int n = 0; n < 3; n++)
      jobs.push_back(make_job($urandom_range(3, 1), $urandom_range(2, 1),
                              $urandom & ((1 << IW) - 1), $urandom & ((1 << WW) - 1),
                              $urandom & ((1 << OW) - 1), 0));
    foreach (jobs[n]) begin
      j = jobs[n];
      total = j.ni * j.nw * PASS + 1;
      done_seen = 0;
      num_ifm_tiles = TW'(j.ni); num_wgt_tiles = TW'(j.nw);
      ifm_base = IW'(j.ib); wgt_base = WW'(j.wb); ofm_base = OW'(j.ob);
      start = 1'b1;
      for (int k = 1; k <= total + 1; k++) begin
        @(negedge clk);
        model_cycle(j, k, ce, av, ie, we, ov, oe);
        if (done) done_seen++;
        vectors++;
        if (obs_ctrl() !== ce) begin
          miscompares++;
          $display("FAIL job%0d ctrl k=%0d got %b want %b", n, k, obs_ctrl(), ce);
        end
        if (av) begin
          vectors++;
          if (ifm_addr_a !== IW'(ie) || wgt_addr_a !== WW'(we)) begin
            miscompares++;
            $display("FAIL job%0d rd_addr k=%0d got ifm=%0d wgt=%0d want ifm=%0d wgt=%0d",
                     n, k, ifm_addr_a, wgt_addr_a, ie, we);
          end
        end
        if (ov) begin
          vectors++;
          if (ofm_addr_b !== OW'(oe)) begin
            miscompares++;
            $display("FAIL job%0d ofm_addr k=%0d got %0d want %0d", n, k, ofm_addr_b, oe);
          end
        end
        if (k == j.repulse_k) begin
          start = 1'b1;
          num_ifm_tiles = TW'(3); num_wgt_tiles = TW'(3);
          ifm_base = IW'($urandom); wgt_base = WW'($urandom); ofm_base = OW'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      vectors++;
      if (done_seen != 1) begin
        miscompares++;
        $display("FAIL job%0d done_count got %0d want 1", n, done_seen);
      end
    end
  endtask

  task automatic test_reset_abort();
    job_t j;
    logic [7:0] ce;
    bit av, ov;
    longint ie, we, oe;
    int total, done_seen, abort_k;
    j = make_job(1, 1, 50, 7, 900, 0);
    abort_k = 1 + 1 + (B + 1) + (2 * S - 1) + 4;
    num_ifm_tiles = 1; num_wgt_tiles = 1;
    ifm_base = IW'(j.ib); wgt_base = WW'(j.wb); ofm_base = OW'(j.ob);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (abort_k - 1) @(negedge clk);
    model_cycle(j, abort_k, ce, av, ie, we, ov, oe);
    vectors++;
    if (obs_ctrl() !== ce) begin
      miscompares++;
      $display("FAIL abort_pre ctrl got %b want %b", obs_ctrl(), ce);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({obs_ctrl(), ifm_addr_a, wgt_addr_a, ofm_addr_b} !== '0) begin
      miscompares++;
      $display("FAIL abort_zero got ctrl=%b ifm=%0d wgt=%0d ofm=%0d want all 0",
               obs_ctrl(), ifm_addr_a, wgt_addr_a, ofm_addr_b);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_ctrl() !== 8'h00) begin
        miscompares++;
        $display("FAIL abort_hold cyc=%0d got %b want 00000000", i, obs_ctrl());
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs_ctrl() !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_release got %b want 00000000", obs_ctrl());
    end
    j = make_job(1, 1, 321, 99, 4000, 0);
    total = PASS + 1;
    done_seen = 0;
    ifm_base = IW'(j.ib); wgt_base = WW'(j.wb); ofm_base = OW'(j.ob);
    start = 1'b1;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      model_cycle(j, k, ce, av, ie, we, ov, oe);
      if (done) done_seen++;
      vectors++;
      if (obs_ctrl() !== ce) begin
        miscompares++;
        $display("FAIL rerun ctrl k=%0d got %b want %b", k, obs_ctrl(), ce);
      end
      if (ov) begin
        vectors++;
        if (ofm_addr_b !== OW'(oe)) begin
          miscompares++;
          $display("FAIL rerun ofm_addr k=%0d got %0d want %0d", k, ofm_addr_b, oe);
        end
      end
    end
    vectors++;
    if (done_seen != 1) begin
      miscompares++;
      $display("FAIL rerun done_count got %0d want 1", done_seen);
    end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    int total;
    total = 2 * PASS + 1;
    num_ifm_tiles = 2; num_wgt_tiles = 1;
    ifm_base = '0; wgt_base = '0; ofm_base = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (total) @(negedge clk);
    vectors++;
    if (perf_cycles !== 32'(total)) begin
      miscompares++;
      $display("FAIL perf_done got %0d want %0d", perf_cycles, total);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (perf_cycles !== 32'(total)) begin
      miscompares++;
      $display("FAIL perf_hold got %0d want %0d", perf_cycles, total);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (perf_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_clear got %0d want 0", perf_cycles);
    end
    repeat (total) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || perf_cycles !== 32'(total)) begin
      miscompares++;
      $display("FAIL perf_second got busy=%b perf=%0d want busy=0 perf=%0d", busy, perf_cycles, total);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_job_table();
    test_reset_abort();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
